dmem_waitstate: RTL and testbench

//  Parametrised data memory for the RISC-V core, replacing the single-cycle dmem.

---
 rtl/dmem_if.sv | 14 +
 rtl/dmem_waitstate.sv | 92 +++++++++
 tb/tb_dmem_waitstate.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the core load/store unit and the data memory.
interface dmem_if #(parameter int XLEN = 32);
   logic            req;
   logic            we;
   logic [2:0]      funct3;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;
   logic            done;
   logic            err;
   logic            stall;
   modport master (output req, we, funct3, addr, wdata, input rdata, done, err, stall);
   modport slave  (input req, we, funct3, addr, wdata, output rdata, done, err, stall);
endinterface

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: byte/half/word data memory with programmable wait states and
// misaligned/illegal access reporting; the core stalls until the done pulse.
module dmem_waitstate #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
   state_t          state, state_next;
   logic [3:0]      cnt;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [AW+1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rdata;
   logic            done;
   logic            err;
   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] word, shifted, load, wd, merged;
   logic [7:0]      lb;
   logic [15:0]     lh;
   logic [3:0]      be;
   logic [1:0]      size;
   logic            sx, bad;
   assign idx     = addr_q[AW+1:2];
   assign word    = mem[idx];
   assign size    = f3_q[1:0];
   assign sx      = ~f3_q[2];
   assign shifted = word >> {addr_q[1:0], 3'b000};
   assign lb      = shifted[7:0];
   assign lh      = addr_q[1] ? word[31:16] : word[15:0];
   // funct3[2] is only legal for LBU/LHU; stores never use it
   assign bad = (size == 2'd3) | (f3_q[2] & (we_q | size == 2'd2))
              | (size == 2'd1 & addr_q[0]) | (size == 2'd2 & addr_q[1:0] != 2'b00);
   assign load = size == 2'd0 ? {{(XLEN-8){sx & lb[7]}}, lb}
               : size == 2'd1 ? {{(XLEN-16){sx & lh[15]}}, lh} : word;
   assign be = size == 2'd0 ? 4'b0001 << addr_q[1:0]
             : size == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd = size == 2'd0 ? {4{wdata_q[7:0]}} : size == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
   always_comb begin
      merged = word;
      for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : word[8*i +: 8];
   end
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = bus.req ? (WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS) : S_IDLE;
         S_WAIT:   state_next = cnt == 4'd1 ? S_ACCESS : S_WAIT;
         S_ACCESS: state_next = S_RESP;
         default:  state_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && bus.req) begin
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            addr_q  <= bus.addr[AW+1:0];
            wdata_q <= bus.wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         done  <= state == S_ACCESS;
         err   <= state == S_ACCESS && bad;
         rdata <= (state == S_ACCESS && !we_q && !bad) ? load : '0;
      end
   end
   always_ff @(posedge clk)
      if (state == S_ACCESS && we_q && !bad) mem[idx] <= merged;
   assign bus.rdata = rdata;
   assign bus.done  = done;
   assign bus.err   = err;
   assign bus.stall = bus.req & ~done;
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: directed checks of load/store sizes, errors, wait-state latency,
// address wrap and reset abort on a 2-wait and a 0-wait instance.
module tb_dmem_waitstate;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rd;
   logic        dn, er, stl;
   int          n_assert = 0, n_fail = 0;
   dmem_if #(.XLEN(32)) b0 ();
   dmem_if #(.XLEN(32)) b1 ();
   dmem_waitstate #(.XLEN(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   dmem_waitstate #(.XLEN(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   assign b0.req = req & ~sel;
   assign b1.req = req & sel;
   assign b0.we = we;
   assign b1.we = we;
   assign b0.funct3 = f3;
   assign b1.funct3 = f3;
   assign b0.addr = addr;
   assign b1.addr = addr;
   assign b0.wdata = wdata;
   assign b1.wdata = wdata;
   assign rd  = sel ? b1.rdata : b0.rdata;
   assign dn  = sel ? b1.done  : b0.done;
   assign er  = sel ? b1.err   : b0.err;
   assign stl = sel ? b1.stall : b0.stall;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // lat counts edges from the accept edge to the edge where done is sampled high
   task automatic xact(input string tag, input logic s, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_r,
                       input logic exp_e, input int exp_lat, input logic drop);
      int lat = -1;
      logic stall_ok = 1'b1;
      @(negedge clk);
      sel = s; we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (drop) req = 1'b0;
         if (dn) begin lat = k + 1; break; end
         if (!drop && !stl) stall_ok = 1'b0;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_rdata"}, rd, exp_r);
      chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
      if (!drop) begin
         chk({tag, "_stall_wait"}, {31'b0, stall_ok}, 32'd1);
         chk({tag, "_stall_done"}, {31'b0, stl}, 32'd0);
      end
      req = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done_clr"}, {31'b0, dn}, 32'd0);
      chk({tag, "_rdata_clr"}, rd, 32'd0);
   endtask
   initial begin
      int seen;
      #12;
      chk("rst_done", {31'b0, b0.done}, 32'd0);
      chk("rst_err", {31'b0, b0.err}, 32'd0);
      chk("rst_rdata", b0.rdata, 32'd0);
      chk("rst_stall", {31'b0, b0.stall}, 32'd0);
      @(negedge clk) reset = 1'b1;
      xact("sw8", 0, 1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 0, 4, 0);
      xact("lw8", 0, 0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 0, 4, 0);
      xact("sw8b", 0, 1, 3'b010, 32'h8, 32'h80FF7F01, 32'h0, 0, 4, 0);
      xact("lb8", 0, 0, 3'b000, 32'h8, 32'h0, 32'h00000001, 0, 4, 0);
      xact("lbB", 0, 0, 3'b000, 32'hB, 32'h0, 32'hFFFFFF80, 0, 4, 0);
      xact("lbuB", 0, 0, 3'b100, 32'hB, 32'h0, 32'h00000080, 0, 4, 0);
      xact("lhA", 0, 0, 3'b001, 32'hA, 32'h0, 32'hFFFF80FF, 0, 4, 0);
      xact("lhuA", 0, 0, 3'b101, 32'hA, 32'h0, 32'h000080FF, 0, 4, 0);
      xact("lb9", 0, 0, 3'b000, 32'h9, 32'h0, 32'h0000007F, 0, 4, 0);
      xact("sw10", 0, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, 4, 0);
      xact("sb11", 0, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 4, 0);
      xact("sh12", 0, 1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 0, 4, 0);
      xact("lw10", 0, 0, 3'b010, 32'h10, 32'h0, 32'hBEEFAA44, 0, 4, 0);
      xact("sw4", 0, 1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 0, 4, 0);
      xact("sw6_mis", 0, 1, 3'b010, 32'h6, 32'hFFFFFFFF, 32'h0, 1, 4, 0);
      xact("sh5_mis", 0, 1, 3'b001, 32'h5, 32'hFFFFFFFF, 32'h0, 1, 4, 0);
      xact("sbu_ill", 0, 1, 3'b100, 32'h4, 32'hFFFFFFFF, 32'h0, 1, 4, 0);
      xact("lh3_mis", 0, 0, 3'b001, 32'h3, 32'h0, 32'h0, 1, 4, 0);
      xact("l011_ill", 0, 0, 3'b011, 32'h4, 32'h0, 32'h0, 1, 4, 0);
      xact("l110_ill", 0, 0, 3'b110, 32'h4, 32'h0, 32'h0, 1, 4, 0);
      xact("lw4_old", 0, 0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 0, 4, 0);
      xact("lw10_drop", 0, 0, 3'b010, 32'h10, 32'h0, 32'hBEEFAA44, 0, 4, 1);
      xact("w0_sw104", 1, 1, 3'b010, 32'h104, 32'h5, 32'h0, 0, 2, 0);
      xact("w0_lw4", 1, 0, 3'b010, 32'h4, 32'h0, 32'h5, 0, 2, 0);
      xact("w0_lhu6", 1, 0, 3'b101, 32'h106, 32'h0, 32'h0, 0, 2, 0);
      @(negedge clk);
      sel = 0; we = 1; f3 = 3'b010; addr = 32'h8; wdata = 32'h55555555; req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_done", {31'b0, dn}, 32'd0);
      chk("abort_err", {31'b0, er}, 32'd0);
      chk("abort_rdata", rd, 32'd0);
      req = 1'b0;
      @(negedge clk) reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (dn) seen++;
      end
      chk("abort_no_done", seen, 0);
      xact("lw8_kept", 0, 0, 3'b010, 32'h8, 32'h0, 32'h80FF7F01, 0, 4, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
